// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared register; grant is registered one edge after req, q updates one edge after wr_en.
// No backpressure: a grant lasts until req drops or MAX_HOLD cycles elapse, followed by one idle cycle.
module shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         wr_en,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         grant,
  output logic               busy,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] LAST_CNT = 8'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         winner;
  logic [1:0]         idx;
  logic               found;

  // Scan starts just past the previous owner, so the previous owner is considered last.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << winner;
          last_d  = winner;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        // last_q always names the current owner while in GRANT.
        if (wr_en[last_q]) begin
          data_d = wdata[int'(last_q)*WIDTH +: WIDTH];
        end
        if (!req[last_q] || cnt_q == LAST_CNT) begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign q     = data_q;

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and write controller for a single shared WIDTH-bit register built from posedge D flip-flops. Four requesters compete for write access. The block grants exactly one at a time, bounds each grant to MAX_HOLD cycles, and steers the granted requester's data into the register. It sits between the requesting sequential blocks and the shared storage, whose output it exposes as `q`.

## Interface
- `WIDTH`, default 8: width of the shared register and of each requester's data slot.
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last. Legal range is 1 to 255.
- `clk` input, 1: clock. All state updates on the rising edge.
- `rst` input, 1: reset. One clock; reset is synchronous and active-high.
- `req` input, 4: per-requester request, level-sensitive.
- `wr_en` input, 4: per-requester write strobe. Honoured only for the granted requester.
- `wdata` input, 4*WIDTH: requester i's data in bits [i*WIDTH +: WIDTH].
- `grant` output, 4: registered, one-hot or zero.
- `busy` output, 1: high while any grant is active (equals |grant).
- `q` output, WIDTH: shared register contents.

## Operation
- State machine with two states:
  - IDLE: grant = 0.
  - GRANT: grant = onehot(g), where g is the current owner.
- Internal state:
  - `last`, 2 bits: most recently granted index.
  - `cnt`, 8 bits: cycles held by the current owner.
- IDLE, at a rising edge:
  - If no req is set, stay in IDLE.
  - Otherwise pick the winner: the first asserted req scanning last+1, last+2, last+3, last (mod 4).
  - Then set state to GRANT, grant to onehot(winner), last to winner, cnt to 0.
- GRANT, at a rising edge:
  - If wr_en[g] is set, load q with wdata slot g.
  - If req[g] is 0 or cnt equals MAX_HOLD-1, go to IDLE and clear grant.
  - Otherwise increment cnt.
- wr_en from non-granted requesters is ignored. wr_en[g] with req[g] low is still honoured on the releasing edge.
- A write and a release on the same edge: the write takes effect.
- q holds its value in all other cycles.
- A timed-out requester that keeps req high re-competes from IDLE. Because last points at it, every other pending requester is served before it.
- A single requester with req held constantly is granted MAX_HOLD cycles, idles 1 cycle, and repeats.

## Timing
- Reset values: grant = 0, busy = 0, q = 0, state = IDLE, last = 3 (requester 0 has highest priority first), cnt = 0.
- rst overrides everything, including a write in the same cycle. Reset during GRANT drops the grant at that edge; the discarded write does not land.
- Grant latency:
  - req sampled high at edge k in IDLE gives grant high after edge k.
  - The requester may present wr_en in the cycle after edge k; q updates at edge k+1.
- Write latency: 1 cycle from the sampled wr_en to q.
- Release: grant goes low on the edge that samples req[g] = 0 or the final held cycle.
- Dead cycle: exactly one IDLE cycle between consecutive grants. Minimum grant-to-grant spacing is 2 cycles.
- Grant length: at most MAX_HOLD cycles high. With MAX_HOLD = 1, each grant lasts exactly 1 cycle.
- req changes in IDLE take effect only at the next edge. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles with req = 4'b1111 and wr_en = 4'b1111 → grant = 0, busy = 0, q = 8'h00 throughout. After rst falls, the first grant is 4'b0001.
- Single write: req = 4'b0100, then wr_en[2] = 1 with slot 2 = 8'hA5 during grant → grant = 4'b0100 one edge after req; q = 8'hA5 one edge after wr_en; grant = 0 one edge after req drops.
- Fairness: req = 4'b1111 held constantly (WIDTH = 8, MAX_HOLD = 4) → grant sequence 0001 ×4, 0000, 0010 ×4, 0000, 0100 ×4, 0000, 1000 ×4, 0000, then 0001 again.
- Isolation: requester 1 granted; wr_en = 4'b1010 with slot 1 = 8'h11 and slot 3 = 8'h3C → q = 8'h11; no write from slot 3.
- Timeout and re-compete: req = 4'b0001 held, plus req[2] raised during cycle 2 of the grant → grant 0001 for exactly 4 cycles, 1 IDLE cycle, then 0100, not 0001.
- Mid-grant reset: requester 3 granted and writing 8'hFF on the same edge as rst = 1 → q = 8'h00, grant = 0. After rst is released with req = 4'b1001, the grant goes to 0001.
